// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the PC and sequences single-outstanding instruction fetches into the F->D register.
// Optional build macro FETCH_MISALIGN_CHECK_EN: a misaligned PC halts fetch and presents an exception payload.
module fetch_ctrl #(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(64'h0000_0000_8000_0000)
) (
    input  logic               clk,
    input  logic               resetn,
    output logic               ireq_valid,
    output logic [ADDR_W-1:0]  ireq_addr,
    input  logic               ireq_ready,
    input  logic               iresp_valid,
    input  logic [INSTR_W-1:0] iresp_data,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               stall,
    output logic               out_valid,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic               out_exc
);

    // REQ issue fetch | WAIT await data | HOLD data buffered, out busy | DISCARD drop stale response
    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DISCARD
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
    logic [ADDR_W-1:0]  hold_pc_q, hold_pc_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
    logic               out_valid_q, out_valid_d;
    logic               out_free;
    logic               req_fire;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic               out_exc_q, out_exc_d;

    assign ireq_valid = (state_q == S_REQ) && (pc_q[1:0] == 2'b00);
    assign out_exc    = out_exc_q;
`else
    assign ireq_valid = (state_q == S_REQ);
    assign out_exc    = 1'b0;
`endif

    assign ireq_addr = pc_q;
    assign req_fire  = ireq_valid && ireq_ready;
    assign out_free  = !out_valid_q || !stall;
    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        out_valid_d  = out_valid_q && stall;
        out_pc_d     = out_pc_q;
        out_instr_d  = out_instr_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
`ifdef FETCH_MISALIGN_CHECK_EN
        out_exc_d    = out_exc_q;
`endif

        if (redirect) begin
            pc_d        = redirect_pc;
            out_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            out_exc_d   = 1'b0;
`endif
            case (state_q)
                S_REQ:             state_d = req_fire ? S_DISCARD : S_REQ;
                S_WAIT, S_DISCARD: state_d = iresp_valid ? S_REQ : S_DISCARD;
                default:           state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (req_fire) begin
                        state_d = S_WAIT;
                    end
`ifdef FETCH_MISALIGN_CHECK_EN
                    else if (pc_q[1:0] != 2'b00 && out_free) begin
                        out_valid_d = 1'b1;
                        out_pc_d    = pc_q;
                        out_instr_d = '0;
                        out_exc_d   = 1'b1;
                    end
`endif
                end
                S_WAIT: begin
                    if (iresp_valid) begin
                        pc_d = pc_q + ADDR_W'(4);
                        if (out_free) begin
                            out_valid_d = 1'b1;
                            out_pc_d    = pc_q;
                            out_instr_d = iresp_data;
`ifdef FETCH_MISALIGN_CHECK_EN
                            out_exc_d   = 1'b0;
`endif
                            state_d     = S_REQ;
                        end else begin
                            hold_pc_d    = pc_q;
                            hold_instr_d = iresp_data;
                            state_d      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_free) begin
                        out_valid_d = 1'b1;
                        out_pc_d    = hold_pc_q;
                        out_instr_d = hold_instr_q;
`ifdef FETCH_MISALIGN_CHECK_EN
                        out_exc_d   = 1'b0;
`endif
                        state_d     = S_REQ;
                    end
                end
                default: begin
                    if (iresp_valid) begin
                        state_d = S_REQ;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_REQ;
            pc_q         <= PC_RESET;
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_instr_q  <= '0;
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            out_exc_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_instr_q  <= out_instr_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            out_exc_q    <= out_exc_d;
`endif
        end
    end

endmodule
